// File: rtl/mem_data_responder.sv
// Word-addressed data-memory responder: req/ack handshake, WAIT_CYCLES wait states, registered read, saturating counters.
// Optional debug read port (dbg_addr/dbg_rdata) is present only when MEM_DATA_RESPONDER_DBG_EN is defined.
module mem_data_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_DATA_RESPONDER_DBG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
`endif
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t              state_q;
  logic [3:0]          wait_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack_q;
  logic                busy_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  // Counters stick at all-ones instead of wrapping.
  assign rd_cnt_d = (rd_cnt_q == {CNT_W{1'b1}}) ? rd_cnt_q : rd_cnt_q + 1'b1;
  assign wr_cnt_d = (wr_cnt_q == {CNT_W{1'b1}}) ? wr_cnt_q : wr_cnt_q + 1'b1;
  assign mem_we   = (state_q == S_ACCESS) && we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            wait_q  <= 4'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (we_q) wr_cnt_q <= wr_cnt_d;
          else begin
            rdata_q  <= mem_q[addr_q];
            rd_cnt_q <= rd_cnt_d;
          end
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a write only happens from ACCESS, so a reset abort discards it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= wdata_q;
  end

`ifdef MEM_DATA_RESPONDER_DBG_EN
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_rdata_q <= '0;
    else        dbg_rdata_q <= mem_q[dbg_addr];
  end

  assign dbg_rdata = dbg_rdata_q;
`endif

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: three instances (2 wait states, 0 wait states, 2-bit counters).
module tb_mem_data_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_v = '0;
  logic [2:0]  we_v = '0;
  logic [9:0]  addr_v [3];
  logic [31:0] wdata_v [3];
  logic [2:0]  ack_v;
  logic [2:0]  busy_v;
  logic [31:0] rdata_v [3];
  logic [15:0] rd_a, wr_a, rd_b, wr_b;
  logic [1:0]  rd_c, wr_c;
  logic [9:0]  dbg_addr_v [3];
  logic [31:0] dbg_rdata_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef MEM_DATA_RESPONDER_DBG_EN
  `define DBG_PORTS(i) .dbg_addr(dbg_addr_v[i]), .dbg_rdata(dbg_rdata_v[i]),
`else
  `define DBG_PORTS(i)
`endif

  mem_data_responder #(.WAIT_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    `DBG_PORTS(0)
    .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .rd_cnt(rd_a), .wr_cnt(wr_a));

  mem_data_responder #(.WAIT_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    `DBG_PORTS(1)
    .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .rd_cnt(rd_b), .wr_cnt(wr_b));

  mem_data_responder #(.WAIT_CYCLES(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
    `DBG_PORTS(2)
    .ack(ack_v[2]), .rdata(rdata_v[2]), .busy(busy_v[2]), .rd_cnt(rd_c), .wr_cnt(wr_c));

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Issues one request on instance d, returns edges from sampling edge to ack (-1 on timeout).
  task automatic txn(input int d, input bit w, input logic [9:0] a, input logic [31:0] dat, output int lat);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = dat;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    chk("busy_in_flight", {31'd0, busy_v[d]}, 32'd1);
    while (!ack_v[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    req_v[d] = 1'b0;
    if (!ack_v[d]) lat = -1;
    @(negedge clk);
    chk("ack_width", {31'd0, ack_v[d]}, 32'd0);
    chk("busy_after", {31'd0, busy_v[d]}, 32'd0);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0; wdata_v[i] = '0; dbg_addr_v[i] = '0;
    end
    vecs[0] = '{1'b1, 10'd5,    32'h0000_00AB, 32'h0000_0000, 1, 0};
    vecs[1] = '{1'b0, 10'd5,    32'h0,         32'h0000_00AB, 1, 1};
    vecs[2] = '{1'b1, 10'd8,    32'h0000_0088, 32'h0000_00AB, 2, 1};
    vecs[3] = '{1'b1, 10'd1023, 32'hDEAD_BEEF, 32'h0000_00AB, 3, 1};
    vecs[4] = '{1'b1, 10'd0,    32'h0BAD_F00D, 32'h0000_00AB, 4, 1};
    vecs[5] = '{1'b0, 10'd1023, 32'h0,         32'hDEAD_BEEF, 4, 2};
    vecs[6] = '{1'b0, 10'd0,    32'h0,         32'h0BAD_F00D, 4, 3};
    vecs[7] = '{1'b1, 10'd6,    32'h1234_5678, 32'h0BAD_F00D, 5, 3};
    vecs[8] = '{1'b0, 10'd6,    32'h0,         32'h1234_5678, 5, 4};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack",   {29'd0, ack_v},  32'd0);
    chk("rst_busy",  {29'd0, busy_v}, 32'd0);
    chk("rst_rdata", rdata_v[0], 32'd0);
    chk("rst_rd_a",  {16'd0, rd_a}, 32'd0);
    chk("rst_wr_a",  {16'd0, wr_a}, 32'd0);
    chk("rst_cnt_c", {28'd0, rd_c, wr_c}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("vec%0d_lat", i), lat, 32'd3);
      chk($sformatf("vec%0d_rdata", i), rdata_v[0], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_wr", i), {16'd0, wr_a}, vecs[i].exp_wr);
      chk($sformatf("vec%0d_rd", i), {16'd0, rd_a}, vecs[i].exp_rd);
    end

`ifdef MEM_DATA_RESPONDER_DBG_EN
    @(negedge clk);
    dbg_addr_v[0] = 10'd5;
    @(negedge clk);
    chk("dbg_rdata", dbg_rdata_v[0], 32'h0000_00AB);
`endif

    // Mid-transaction address/data change is ignored.
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'd7; wdata_v[0] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    addr_v[0] = 10'd8; wdata_v[0] = 32'h66;
    lat = 0;
    while (!ack_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    req_v[0] = 1'b0;
    chk("midchg_ack", {31'd0, ack_v[0]}, 32'd1);
    @(negedge clk);
    txn(0, 1'b0, 10'd7, 32'h0, lat);
    chk("midchg_mem7", rdata_v[0], 32'h55);
    txn(0, 1'b0, 10'd8, 32'h0, lat);
    chk("midchg_mem8", rdata_v[0], 32'h88);

    // Instance b, zero wait states: preload then back-to-back loads with req held.
    txn(1, 1'b1, 10'd0, 32'h11, lat);
    chk("b_store_lat", lat, 32'd1);
    txn(1, 1'b1, 10'd1, 32'h22, lat);
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 10'd0;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) addr_v[1] = 10'd1;
      chk($sformatf("b2b_ack_k%0d", k), {31'd0, ack_v[1]}, {31'd0, (k == 1 || k == 4)});
      if (k == 1) chk("b2b_rdata0", rdata_v[1], 32'h11);
      if (k == 4) begin
        chk("b2b_rdata1", rdata_v[1], 32'h22);
        req_v[1] = 1'b0;
      end
    end
    chk("b_rd_cnt", {16'd0, rd_b}, 32'd2);

    // Instance c, 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      txn(2, 1'b1, 10'(i), 32'(i), lat);
      chk($sformatf("c_wr_sat%0d", i), {30'd0, wr_c}, (i < 3) ? i + 1 : 3);
    end
    chk("c_rd_zero", {30'd0, rd_c}, 32'd0);

    // Reset abort during WAIT of a store.
    txn(0, 1'b1, 10'd3, 32'h99, lat);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'd3; wdata_v[0] = 32'h77;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy_v[0]}, 32'd1);
    rst_n = 1'b0;
    req_v[0] = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_ack", {31'd0, ack_v[0]}, 32'd0);
    end
    chk("abort_rdata", rdata_v[0], 32'd0);
    chk("abort_cnts", {rd_a, wr_a}, 32'd0);
    rst_n = 1'b1;
    txn(0, 1'b0, 10'd3, 32'h0, lat);
    chk("abort_lat", lat, 32'd3);
    chk("abort_mem3", rdata_v[0], 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_data_responder.md
Name: mem_data_responder

Overview:
- Word-addressed data-memory responder: the slave end of the MIPS load/store path.
- Accepts one request at a time over a req/ack handshake, inserts a configurable number of wait states, then performs the write or a registered read.
- Sits between the multicycle core's Memory stage and on-chip storage, and replaces the direct fixed-latency RAM attachment.
- Keeps saturating access counters for board display.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 10, word-address width; depth = 2**ADDR_W
- WAIT_CYCLES, 2, wait states inserted before each access (0..15)
- CNT_W, 16, width of the read/write access counters

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  request valid; held high by the initiator until ack
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  ADDR_W  word address (core drives ALU result [9:0])
- wdata  in  DATA_W  store data
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  load data; valid when ack=1 and held until the next load completes
- busy  out  1  high while a request is in flight (state != IDLE)
- rd_cnt  out  CNT_W  completed loads, saturating
- wr_cnt  out  CNT_W  completed stores, saturating

Behaviour:
- Reset values: ack=0, rdata=0, busy=0, rd_cnt=0, wr_cnt=0, state=IDLE, wait counter=0. Storage array is not cleared by reset.
- State machine:
  - IDLE: when req=1, latch addr/we/wdata into internal registers and load wait counter = WAIT_CYCLES. Next state is WAIT, or ACCESS if WAIT_CYCLES=0.
  - WAIT: decrement the counter each edge; go to ACCESS on the edge where the counter reaches 0.
  - ACCESS: if latched we=1, write mem[addr]=wdata, increment wr_cnt, leave rdata unchanged. Else rdata<=mem[addr] and increment rd_cnt. Set ack<=1 and go to DONE.
  - DONE: ack<=0; go to IDLE.
- Latency: ack is high during the cycle after edge E0+WAIT_CYCLES+1, where E0 is the sampling edge. Ack width is exactly 1 cycle.
- Throughput: one access per WAIT_CYCLES+3 cycles. If req is still high in IDLE after DONE, it is a new request (back-to-back allowed).
- Request inputs are ignored outside IDLE. A change of addr/we/wdata mid-transaction has no effect, because the latched copies are used.
- Address: the full ADDR_W bits are used. There is no out-of-range condition, since the address wraps modulo the depth.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- busy = (state != IDLE), registered.
- Reset asserted mid-transaction: return immediately to IDLE with all outputs at reset values. A store that has not reached ACCESS is discarded; memory is left unmodified.

Optional Feature:
- Macro MEM_DATA_RESPONDER_DBG_EN.
- When defined, add input dbg_addr [ADDR_W-1:0] and output dbg_rdata [DATA_W-1:0]. This is a second, independent registered read port: dbg_rdata = mem[dbg_addr] one cycle later, for driving the board 7-segment displays from switches.
- The debug port never stalls or affects the main port. A debug read of an address written in the same cycle returns the old data.
- When undefined, these ports and their logic are absent.

Test Plan:
- Reset value check: hold rst_n=0, then release -> ack=0, busy=0, rdata=0, rd_cnt=0, wr_cnt=0.
- Store then load, WAIT_CYCLES=2: req=1, we=1, addr=5, wdata=0x0000_00AB -> ack for exactly one cycle at E0+3, wr_cnt=1. Then req, we=0, addr=5 -> rdata=0x0000_00AB with ack, rd_cnt=1.
- WAIT_CYCLES=0 back-to-back: req held high for two loads at addr 0 and 1 (preloaded 0x11, 0x22) -> ack at E0+1 and again 3 cycles later, with rdata 0x11 then 0x22.
- Mid-transaction input change: start store addr=7, data=0x55, then switch addr to 8 during WAIT -> mem[7]=0x55 and mem[8] unchanged.
- Reset abort: assert rst_n=0 during WAIT of a store to addr 3 (old value 0x99) -> no ack, busy=0, and a later load of addr 3 returns 0x99.
- Counter saturation (CNT_W=2): 5 stores -> wr_cnt stays 3. Address wrap: addr=1023 then 0 access distinct words. With DBG_EN: dbg_addr=5 -> dbg_rdata=0xAB one cycle later.
